// File: rtl/stack_engine.sv
// PUSH/POP sequencer between decode and the 16-bit register file.
// Reads SP and a source register, moves one word to/from memory, writes back.
module stack_engine #(
   parameter logic [3:0]  SP_IDX      = 4'd13,
   parameter logic [15:0] STACK_LIMIT = 16'hFF00,
   parameter logic [15:0] STACK_TOP   = 16'hFFFF,
   parameter logic [3:0]  TIMEOUT     = 4'd15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        req_pop,
   input  logic [3:0]  req_reg,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [3:0]  rf_ra1,
   output logic [3:0]  rf_ra2,
   input  logic [15:0] rf_rd1,
   input  logic [15:0] rf_rd2,
   output logic        rf_we,
   output logic [3:0]  rf_wa,
   output logic [15:0] rf_wd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MEM,
      S_WB_SP,
      S_WB_REG,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        pop_q, pop_d;
   logic [3:0]  reg_q, reg_d;
   logic [15:0] sp_q, sp_d;
   logic [15:0] data_q, data_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        err_q, err_d;

   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic        rf_we_q, rf_we_d;
   logic [3:0]  rf_wa_q, rf_wa_d;
   logic [15:0] rf_wd_q, rf_wd_d;

   logic        bound_err;

   assign rf_ra1    = SP_IDX;
   assign rf_ra2    = req_reg;
   assign ready     = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rf_we     = rf_we_q;
   assign rf_wa     = rf_wa_q;
   assign rf_wd     = rf_wd_q;

   // Overflow/underflow is judged on the SP read in the accept cycle.
   assign bound_err = req_pop ? (rf_rd1 == STACK_TOP)
                              : (rf_rd1 == STACK_LIMIT);

   // Next-state, operand latches and next values of the registered outputs.
   always_comb begin
      state_d = state_q;
      pop_d   = pop_q;
      reg_d   = reg_q;
      sp_d    = sp_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               pop_d  = req_pop;
               reg_d  = req_reg;
               sp_d   = rf_rd1;
               data_d = rf_rd2;
               cnt_d  = 4'd0;
               err_d  = 1'b0;
               if (bound_err) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_MEM;
               end
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               if (pop_q) begin
                  data_d = mem_rdata;
               end
               state_d = S_WB_SP;
            end else begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_d == TIMEOUT) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_WB_SP: begin
            state_d = pop_q ? S_WB_REG : S_DONE;
         end
         S_WB_REG: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they leave a flop.
      ready_d     = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      mem_req_d   = (state_d == S_MEM);
      mem_we_d    = mem_req_d & ~pop_d;
      mem_addr_d  = 16'd0;
      mem_wdata_d = 16'd0;
      if (mem_req_d) begin
         mem_addr_d  = pop_d ? sp_d + 16'd1 : sp_d;
         mem_wdata_d = data_d;
      end

      rf_we_d = 1'b0;
      rf_wa_d = 4'd0;
      rf_wd_d = 16'd0;
      if (state_d == S_WB_SP) begin
         rf_we_d = 1'b1;
         rf_wa_d = SP_IDX;
         rf_wd_d = pop_d ? sp_d + 16'd1 : sp_d - 16'd1;
      end else if (state_d == S_WB_REG) begin
         rf_we_d = 1'b1;
         rf_wa_d = reg_d;
         rf_wd_d = data_d;
      end
   end

   // State, operand and output registers; reset aborts with no done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pop_q       <= 1'b0;
         reg_q       <= 4'd0;
         sp_q        <= 16'd0;
         data_q      <= 16'd0;
         cnt_q       <= 4'd0;
         err_q       <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 16'd0;
         mem_wdata_q <= 16'd0;
         rf_we_q     <= 1'b0;
         rf_wa_q     <= 4'd0;
         rf_wd_q     <= 16'd0;
      end else begin
         state_q     <= state_d;
         pop_q       <= pop_d;
         reg_q       <= reg_d;
         sp_q        <= sp_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rf_we_q     <= rf_we_d;
         rf_wa_q     <= rf_wa_d;
         rf_wd_q     <= rf_wd_d;
      end
   end

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: regfile + memory models, scoreboard queues
// filled when an operation is issued and drained by a negedge monitor.
module tb_stack_engine;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wd;
   } mx_t;

   typedef struct {
      logic [3:0]  wa;
      logic [15:0] wd;
   } rx_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        req_pop = 1'b0;
   logic [3:0]  req_reg = 4'd0;
   logic        ready, busy, done, err;
   logic [3:0]  rf_ra1, rf_ra2;
   logic [15:0] rf_rd1, rf_rd2;
   logic        rf_we;
   logic [3:0]  rf_wa;
   logic [15:0] rf_wd;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   int total = 0;
   int bad = 0;

   logic [15:0] rf [16];
   logic [15:0] mem [65536];
   logic [15:0] sh [16];
   logic [15:0] smem [logic [15:0]];

   logic        pl_en = 1'b0;
   logic [3:0]  pl_idx = 4'd0;
   logic [15:0] pl_val = 16'd0;

   int ack_delay = 0;
   int wait_cnt = 0;
   int mreq_cycles = 0;

   mx_t exp_mem [$];
   rx_t exp_rf [$];
   logic exp_done [$];

   stack_engine dut (
      .clk(clk), .rst(rst),
      .req(req), .req_pop(req_pop), .req_reg(req_reg),
      .ready(ready), .busy(busy), .done(done), .err(err),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   assign rf_rd1    = rf[rf_ra1];
   assign rf_rd2    = rf[rf_ra2];
   assign mem_rdata = mem[mem_addr];
   assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

   // Regfile model: reset restores SP, DUT writes and bench preloads.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
         rf[13] <= 16'hFFFF;
      end else begin
         if (rf_we) rf[rf_wa] <= rf_wd;
         if (pl_en) rf[pl_idx] <= pl_val;
      end
   end

   // Memory model with programmable ack delay.
   always @(posedge clk) begin
      wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
      if (mem_req) mreq_cycles <= mreq_cycles + 1;
      if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
   end

   // Monitor: every mem, rf write and done event must match the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req) begin
            total++;
            assert (exp_mem.size() != 0) else begin
               bad++;
               $error("FAIL unexpected_mem_req observed addr=%h expected none", mem_addr);
            end
            if (exp_mem.size() != 0) begin
               total++;
               assert ({mem_we, mem_addr, mem_wdata} ===
                       {exp_mem[0].we, exp_mem[0].addr, exp_mem[0].wd}) else begin
                  bad++;
                  $error("FAIL mem_bus observed we=%b a=%h d=%h expected we=%b a=%h d=%h",
                         mem_we, mem_addr, mem_wdata,
                         exp_mem[0].we, exp_mem[0].addr, exp_mem[0].wd);
               end
               if (mem_ack) void'(exp_mem.pop_front());
            end
         end
         if (rf_we) begin
            total++;
            assert (exp_rf.size() != 0) else begin
               bad++;
               $error("FAIL unexpected_rf_we observed wa=%h wd=%h expected none", rf_wa, rf_wd);
            end
            if (exp_rf.size() != 0) begin
               total++;
               assert ({rf_wa, rf_wd} === {exp_rf[0].wa, exp_rf[0].wd}) else begin
                  bad++;
                  $error("FAIL rf_write observed wa=%h wd=%h expected wa=%h wd=%h",
                         rf_wa, rf_wd, exp_rf[0].wa, exp_rf[0].wd);
               end
               void'(exp_rf.pop_front());
            end
         end
         if (done) begin
            total++;
            assert (exp_done.size() != 0) else begin
               bad++;
               $error("FAIL unexpected_done observed done=1 expected 0");
            end
            if (exp_done.size() != 0) begin
               total++;
               assert (err === exp_done[0]) else begin
                  bad++;
                  $error("FAIL done_err observed=%b expected=%b", err, exp_done[0]);
               end
               void'(exp_done.pop_front());
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
      pl_en = 1'b1;
      pl_idx = r;
      pl_val = v;
      tick();
      pl_en = 1'b0;
      sh[r] = v;
   endtask

   task automatic shadow_reset();
      for (int i = 0; i < 16; i++) sh[i] = 16'h0000;
      sh[13] = 16'hFFFF;
   endtask

   // Issue one op; expectations come from the bench's own shadow state.
   task automatic do_op(input logic pop, input logic [3:0] r,
                        input int lat, input logic to, input string tag);
      logic [15:0] sp, d, rd, a;
      logic bnd, e;
      int n;
      sp  = sh[13];
      d   = sh[r];
      bnd = pop ? (sp == 16'hFFFF) : (sp == 16'hFF00);
      e   = bnd | to;
      a   = pop ? sp + 16'd1 : sp;
      if (!bnd) exp_mem.push_back('{we: ~pop, addr: a, wd: d});
      if (!e) begin
         if (pop) begin
            rd = smem.exists(a) ? smem[a] : 16'hxxxx;
            exp_rf.push_back('{wa: 4'd13, wd: sp + 16'd1});
            exp_rf.push_back('{wa: r, wd: rd});
            sh[13] = sp + 16'd1;
            sh[r]  = rd;
         end else begin
            smem[sp] = d;
            exp_rf.push_back('{wa: 4'd13, wd: sp - 16'd1});
            sh[13] = sp - 16'd1;
         end
      end
      exp_done.push_back(e);
      mreq_cycles = 0;
      req = 1'b1;
      req_pop = pop;
      req_reg = r;
      tick();
      req = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 16'(n), 16'(lat));
      tick();
      if (to) begin
         chk({tag, "_mreq_cycles"}, 16'(mreq_cycles), 16'd15);
         chk({tag, "_left_mem"}, 16'(exp_mem.size()), 16'd1);
         exp_mem.delete();
      end
   endtask

   initial begin
      shadow_reset();
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ready", 16'(ready), 16'd1);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_err", 16'(err), 16'd0);
      chk("rst_mem_req", 16'(mem_req), 16'd0);
      chk("rst_rf_we", 16'(rf_we), 16'd0);
      chk("rst_ra1", 16'(rf_ra1), 16'd13);

      set_reg(4'd2, 16'h1234);
      do_op(1'b0, 4'd2, 3, 1'b0, "push_r2");
      chk("sp_after_push", rf[13], 16'hFFFE);

      do_op(1'b1, 4'd5, 4, 1'b0, "pop_r5");
      chk("sp_after_pop", rf[13], 16'hFFFF);
      chk("r5_after_pop", rf[5], 16'h1234);

      do_op(1'b1, 4'd6, 1, 1'b0, "underflow");
      chk("sp_after_underflow", rf[13], 16'hFFFF);

      set_reg(4'd13, 16'hFF00);
      do_op(1'b0, 4'd2, 1, 1'b0, "overflow");
      set_reg(4'd13, 16'hFF01);
      do_op(1'b0, 4'd2, 3, 1'b0, "push_ff01");
      chk("sp_at_limit", rf[13], 16'hFF00);

      set_reg(4'd13, 16'hFFF0);
      set_reg(4'd3, 16'hBEEF);
      ack_delay = 100;
      do_op(1'b0, 4'd3, 16, 1'b1, "timeout");
      chk("sp_after_timeout", rf[13], 16'hFFF0);
      ack_delay = 3;
      do_op(1'b0, 4'd3, 6, 1'b0, "wait3");
      chk("sp_after_wait3", rf[13], 16'hFFEF);

      ack_delay = 100;
      exp_mem.push_back('{we: 1'b1, addr: 16'hFFEF, wd: 16'hBEEF});
      req = 1'b1;
      req_pop = 1'b0;
      req_reg = 4'd3;
      tick();
      req = 1'b0;
      tick();
      tick();
      chk("mid_mem_req", 16'(mem_req), 16'd1);
      rst = 1'b1;
      exp_mem.delete();
      tick();
      chk("abort_ready", 16'(ready), 16'd1);
      chk("abort_mem_req", 16'(mem_req), 16'd0);
      chk("abort_done", 16'(done), 16'd0);
      rst = 1'b0;
      shadow_reset();
      ack_delay = 0;
      tick();
      tick();

      set_reg(4'd4, 16'h0100);
      do_op(1'b0, 4'd4, 3, 1'b0, "push_r4");
      do_op(1'b1, 4'd13, 4, 1'b0, "pop_sp");
      chk("sp_popped", rf[13], 16'h0100);

      chk("left_mem", 16'(exp_mem.size()), 16'd0);
      chk("left_rf", 16'(exp_rf.size()), 16'd0);
      chk("left_done", 16'(exp_done.size()), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
